// File: rtl/param_misr_checker.sv
// param_misr_checker: parametrised Galois MISR that compacts a counted beat stream and
// compares the final signature with a golden value. It includes a one-shot bit-flip injector.
`default_nettype none

module param_misr_checker #(
  parameter int             W      = 8,
  parameter logic [W-1:0]   POLY   = 8'h1D,
  parameter logic [W-1:0]   SEED   = 8'h01,
  parameter int             CNT_W  = 8,
  parameter bit             INJ_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 m_rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic [W-1:0]         golden,
  input  logic                 din_valid,
  input  logic [W-1:0]         din,
  input  logic                 inj_req,
  input  logic [$clog2(W)-1:0] inj_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [W-1:0]         signature,
  output logic                 inj_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;
  logic [W-1:0]       golden_q;

  logic               inj_fire;
  logic [W-1:0]       flip_mask;
  logic [W-1:0]       din_eff;
  logic [W-1:0]       sig_next;
  logic [CNT_W:0]     cnt_inc;
  logic               last_beat;

  generate
    if (INJ_EN) begin : g_inj
      assign inj_fire = inj_req & din_valid & busy & ~inj_error;
    end else begin : g_no_inj
      assign inj_fire = 1'b0;
    end
  endgenerate

  // An index past the top bit shifts the one out of range, so no bit is flipped,
  // but the sticky flag is still set.
  assign flip_mask = inj_fire ? ({{(W-1){1'b0}}, 1'b1} << inj_idx) : '0;
  assign din_eff   = din ^ flip_mask;
  assign sig_next  = {signature[W-2:0], 1'b0} ^ (signature[W-1] ? POLY : '0) ^ din_eff;

  // The count is compared one bit wider, so a maximum len terminates without wrapping.
  assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last_beat = (cnt_inc == {1'b0, len_q});

  always_ff @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      inj_error <= 1'b0;
      signature <= SEED;
      cnt       <= '0;
      len_q     <= '0;
      golden_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            len_q     <= len;
            golden_q  <= golden;
            signature <= SEED;
            cnt       <= '0;
            inj_error <= 1'b0;
            if (len == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (SEED == golden);
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              pass  <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (din_valid) begin
            signature <= sig_next;
            cnt       <= cnt_inc[CNT_W-1:0];
            if (inj_fire) begin
              inj_error <= 1'b1;
            end
            if (last_beat) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == golden_q);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_param_misr_checker.sv
// Testbench for param_misr_checker. It checks the design against a reference model of MISR arithmetic.
`default_nettype none

module tb_param_misr_checker;

  logic       clk;
  logic       m_rst_n;
  logic       start;
  logic [7:0] len;
  logic [7:0] golden;
  logic       din_valid;
  logic [7:0] din;
  logic       inj_req;
  logic [2:0] inj_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;
  logic       inj_error;

  int checks   = 0;
  int failures = 0;

  param_misr_checker dut (
    .clk       (clk),
    .m_rst_n   (m_rst_n),
    .start     (start),
    .len       (len),
    .golden    (golden),
    .din_valid (din_valid),
    .din       (din),
    .inj_req   (inj_req),
    .inj_idx   (inj_idx),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .inj_error (inj_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: multiply by x modulo x^8+x^4+x^3+x^2+1, then add the data word.
  function automatic logic [7:0] step(input logic [7:0] s, input logic [7:0] d);
    int t;
    t = (int'(s) * 2) % 256;
    if (int'(s) >= 128) t = t ^ 'h1D;
    return 8'(t) ^ d;
  endfunction

  task automatic kick(input logic [7:0] n, input logic [7:0] g);
    start = 1'b1; len = n; golden = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic ir, input logic [2:0] ii);
    din_valid = v; din = d; inj_req = ir; inj_idx = ii;
    @(negedge clk);
    din_valid = 1'b0; inj_req = 1'b0;
  endtask

  task automatic test_reset;
    m_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
    checks++; if (inj_error !== 1'b0) begin failures++; $display("FAIL reset_inj got=%b exp=0", inj_error); end
    checks++; if (signature !== 8'h01) begin failures++; $display("FAIL reset_sig got=%h exp=01", signature); end
    m_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_stream;
    logic [7:0] exp_sig [3];
    exp_sig[0] = 8'h02; exp_sig[1] = 8'h04; exp_sig[2] = 8'h08;
    kick(8'd3, 8'h08);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_start got=%b exp=1", busy); end
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 8'h00, 1'b0, 3'd0);
      checks++; if (signature !== exp_sig[i]) begin failures++; $display("FAIL zero_sig[%0d] got=%h exp=%h", i, signature, exp_sig[i]); end
      checks++; if (done !== (i == 2)) begin failures++; $display("FAIL zero_done[%0d] got=%b exp=%b", i, done, (i == 2)); end
      checks++; if (busy !== (i != 2)) begin failures++; $display("FAIL zero_busy[%0d] got=%b exp=%b", i, busy, (i != 2)); end
    end
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL zero_pass got=%b exp=1", pass); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    checks++; if (signature !== 8'h08 || pass !== 1'b1) begin failures++; $display("FAIL zero_hold got=%h/%b exp=08/1", signature, pass); end
  endtask

  task automatic test_poly_wrap;
    logic [7:0] m;
    m = 8'h01;
    kick(8'd8, 8'h1D);
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, 8'h00, 1'b0, 3'd0);
      m = step(m, 8'h00);
      checks++; if (signature !== m) begin failures++; $display("FAIL wrap_sig[%0d] got=%h exp=%h", i, signature, m); end
    end
    checks++; if (signature !== 8'h1D) begin failures++; $display("FAIL wrap_final got=%h exp=1d", signature); end
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL wrap_done_pass got=%b/%b exp=1/1", done, pass); end
    @(negedge clk);
  endtask

  task automatic test_injection;
    logic [7:0] d1, d2, m;
    kick(8'd1, 8'h02);
    beat(1'b1, 8'h00, 1'b1, 3'd7);
    checks++; if (signature !== 8'h82) begin failures++; $display("FAIL inj_sig got=%h exp=82", signature); end
    checks++; if (inj_error !== 1'b1) begin failures++; $display("FAIL inj_flag got=%b exp=1", inj_error); end
    checks++; if (pass !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL inj_pass_done got=%b/%b exp=0/1", pass, done); end
    @(negedge clk);
    beat(1'b1, 8'h55, 1'b1, 3'd2);
    checks++; if (signature !== 8'h82 || inj_error !== 1'b1) begin failures++; $display("FAIL inj_idle got=%h/%b exp=82/1", signature, inj_error); end
    d1 = 8'($urandom); d2 = 8'($urandom);
    kick(8'd2, 8'h00);
    checks++; if (inj_error !== 1'b0) begin failures++; $display("FAIL inj_clear got=%b exp=0", inj_error); end
    beat(1'b1, d1, 1'b1, 3'd0);
    checks++; if (inj_error !== 1'b1) begin failures++; $display("FAIL inj_second_flag got=%b exp=1", inj_error); end
    beat(1'b1, d2, 1'b1, 3'd1);
    m = step(step(8'h01, d1 ^ 8'h01), d2);
    checks++; if (signature !== m) begin failures++; $display("FAIL inj_oneshot got=%h exp=%h", signature, m); end
    checks++; if (pass !== (m == 8'h00)) begin failures++; $display("FAIL inj_oneshot_pass got=%b exp=%b", pass, (m == 8'h00)); end
    @(negedge clk);
  endtask

  task automatic test_stalls_len0;
    logic [7:0] d1, d2, m;
    logic       vpat [4];
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1;
    d1 = 8'($urandom); d2 = 8'($urandom);
    m = step(step(8'h01, d1), d2);
    kick(8'd2, m);
    for (int i = 0; i < 4; i++) begin
      beat(vpat[i], (i == 0) ? d1 : ((i == 3) ? d2 : 8'($urandom)), 1'b0, 3'd0);
      checks++; if (done !== (i == 3)) begin failures++; $display("FAIL stall_done[%0d] got=%b exp=%b", i, done, (i == 3)); end
    end
    checks++; if (signature !== m || pass !== 1'b1) begin failures++; $display("FAIL stall_sig got=%h/%b exp=%h/1", signature, pass, m); end
    @(negedge clk);
    kick(8'd0, 8'h01);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL len0_done got=%b/%b exp=1/0", done, busy); end
    checks++; if (signature !== 8'h01 || pass !== 1'b1) begin failures++; $display("FAIL len0_sig got=%h/%b exp=01/1", signature, pass); end
    @(negedge clk);
    kick(8'd0, 8'h02);
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL len0_fail got=%b/%b exp=1/0", done, pass); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int dones;
    dones = 0;
    kick(8'd5, 8'h00);
    beat(1'b1, 8'hA5, 1'b0, 3'd0);
    beat(1'b1, 8'h3C, 1'b0, 3'd0);
    din_valid = 1'b1; din = 8'h11;
    #2 m_rst_n = 1'b0;
    #1;
    checks++; if (signature !== 8'h01 || busy !== 1'b0) begin failures++; $display("FAIL midrst_async got=%h/%b exp=01/0", signature, busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL midrst_nodone got=%0d exp=0", dones); end
    m_rst_n = 1'b1; din_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b/%b exp=0/0", busy, done); end
    kick(8'd3, 8'h08);
    for (int i = 0; i < 3; i++) beat(1'b1, 8'h00, 1'b0, 3'd0);
    checks++; if (signature !== 8'h08 || done !== 1'b1 || pass !== 1'b1) begin failures++; $display("FAIL midrst_fresh got=%h/%b/%b exp=08/1/1", signature, done, pass); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    logic [7:0] m, d;
    int dones;
    dones = 0;
    m = 8'h01;
    kick(8'd4, 8'h00);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      start = 1'b1; len = 8'd0; golden = 8'hFF;
      beat(1'b1, d, 1'b0, 3'd0);
      start = 1'b0;
      m = step(m, d);
      if (done === 1'b1) dones++;
      checks++; if (signature !== m) begin failures++; $display("FAIL ign_sig[%0d] got=%h exp=%h", i, signature, m); end
    end
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    if (done === 1'b1) dones++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL ign_done_start got=%b/%b exp=0/0", busy, done); end
    @(negedge clk);
    if (done === 1'b1) dones++;
    checks++; if (dones !== 1) begin failures++; $display("FAIL ign_single_done got=%0d exp=1", dones); end
    checks++; if (signature !== m || busy !== 1'b0) begin failures++; $display("FAIL ign_hold got=%h/%b exp=%h/0", signature, busy, m); end
  endtask

  task automatic test_random;
    logic [7:0] data [16];
    logic [7:0] m, g;
    logic [2:0] idx;
    int n, ib, b, cyc, dones;
    logic v;
    for (int r = 0; r < 25; r++) begin
      n   = $urandom_range(1, 12);
      ib  = $urandom_range(0, n + 2);
      idx = 3'($urandom);
      m = 8'h01;
      for (int i = 0; i < n; i++) begin
        data[i] = 8'($urandom);
        m = step(m, (i == ib) ? (data[i] ^ (8'h01 << idx)) : data[i]);
      end
      g = ($urandom % 2 == 0) ? m : (m ^ 8'($urandom_range(1, 255)));
      kick(8'(n), g);
      b = 0; cyc = 0; dones = 0;
      while (b < n && cyc < 4 * n + 20) begin
        v = ($urandom % 3) != 0;
        beat(v, data[b], (b >= ib), idx);
        cyc++;
        if (v) b++;
        if (done === 1'b1 && b < n) dones++;
      end
      checks++; if (b !== n) begin failures++; $display("FAIL rnd_budget[%0d] got=%0d exp=%0d", r, b, n); end
      checks++; if (dones !== 0 || done !== 1'b1) begin failures++; $display("FAIL rnd_done[%0d] early=%0d final=%b", r, dones, done); end
      checks++; if (signature !== m) begin failures++; $display("FAIL rnd_sig[%0d] got=%h exp=%h", r, signature, m); end
      checks++; if (pass !== (g == m)) begin failures++; $display("FAIL rnd_pass[%0d] got=%b exp=%b", r, pass, (g == m)); end
      checks++; if (inj_error !== (ib < n)) begin failures++; $display("FAIL rnd_inj[%0d] got=%b exp=%b", r, inj_error, (ib < n)); end
      @(negedge clk);
    end
  endtask

  initial begin
    m_rst_n = 1'b0; start = 1'b0; len = '0; golden = '0;
    din_valid = 1'b0; din = '0; inj_req = 1'b0; inj_idx = '0;
    @(negedge clk);
    test_reset;
    test_zero_stream;
    test_poly_wrap;
    test_injection;
    test_stalls_len0;
    test_reset_midrun;
    test_ignored_start;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
